// File: rtl/mips_pkg.sv
// Constants and types shared between the fetch stage and the decode controller.
package mips_pkg;

  localparam logic [31:0] NopInstr       = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] FunctJr   = 6'h08;

  typedef enum logic [1:0] {
    RedirNone,
    RedirBranch,
    RedirJr,
    RedirJump
  } redir_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

  function automatic logic is_jump(input logic [31:0] instr);
    return (instr[31:26] == OpJ) || (instr[31:26] == OpJal);
  endfunction

  function automatic logic is_jr(input logic [31:0] instr);
    return (instr[31:26] == OpSpecial) && (instr[5:0] == FunctJr);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; flush takes priority over hold.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NopInstr
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  if_id_t if_id_d, if_id_q;

  always_comb begin
    if_id_d = if_id_q;
    if (flush_i) begin
      if_id_d = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
    end else if (!hold_i) begin
      if_id_d = '{instr: instr_i, pc_plus4: pc_plus4_i, valid: 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_id_q <= '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign instr_o    = if_id_q.instr;
  assign pc_plus4_o = if_id_q.pc_plus4;
  assign valid_o    = if_id_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, redirect selection, IF/ID register and
// saturating stall/flush counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = ResetPcDefault,
  parameter logic [31:0] NOP_INSTR = NopInstr,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 stall_i,
  input  logic                 id_jump_i,
  input  logic                 id_jr_i,
  input  logic [31:0]          id_jr_target_i,
  input  logic                 ex_branch_taken_i,
  input  logic [31:0]          ex_branch_target_i,
  output logic [31:0]          im_addr_o,
  input  logic [31:0]          im_rdata_i,
  output logic [31:0]          if_id_instr_o,
  output logic [31:0]          if_id_pc_plus4_o,
  output logic                 if_id_valid_o,
  output logic                 id_flush_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [31:0]          pc_d, pc_q;
  logic [31:0]          pc_plus4;
  logic [31:0]          redir_target;
  redir_e               redir_sel;
  logic                 redirect;
  logic                 stall_apply;
  logic [CNT_WIDTH-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_d, flush_cnt_q;

  assign pc_plus4 = pc_q + 32'd4;

  // EX branch is the older instruction, so it beats anything decoded in ID.
  always_comb begin
    redir_sel = RedirNone;
    if (ex_branch_taken_i) begin
      redir_sel = RedirBranch;
    end else if (if_id_valid_o && id_jr_i) begin
      redir_sel = RedirJr;
    end else if (if_id_valid_o && id_jump_i) begin
      redir_sel = RedirJump;
    end
  end

  always_comb begin
    redir_target = pc_plus4;
    unique case (redir_sel)
      RedirBranch: redir_target = ex_branch_target_i;
      RedirJr:     redir_target = id_jr_target_i;
      RedirJump:   redir_target = jump_target(if_id_pc_plus4_o, if_id_instr_o);
      default:     redir_target = pc_plus4;
    endcase
  end

  assign redirect    = (redir_sel != RedirNone);
  assign stall_apply = stall_i && !redirect;

  always_comb begin
    pc_d = pc_plus4;
    if (redirect) begin
      pc_d = redir_target & ~32'h3;
    end else if (stall_apply) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_apply && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (redirect && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= RESET_PC;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .hold_i     (stall_i),
    .flush_i    (redirect),
    .instr_i    (im_rdata_i),
    .pc_plus4_i (pc_plus4),
    .instr_o    (if_id_instr_o),
    .pc_plus4_o (if_id_pc_plus4_o),
    .valid_o    (if_id_valid_o)
  );

  assign im_addr_o   = pc_q;
  assign id_flush_o  = ex_branch_taken_i;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
